// File: rtl/voq_seq_tagger_pkg.sv
// Shared widths, header field positions and FSM encodings for the VOQ sequence tagger.
// Header layout: dest port in the top WIDTH_SEL bits, body length above the priority and CRC fields.
package voq_seq_tagger_pkg;

  localparam int PORT_NUB_TOTAL = 8;
  localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
  localparam int DATA_WIDTH     = 64;
  localparam int WIDTH_LENGTH   = 8;
  localparam int WIDTH_PRIORITY = 3;
  localparam int CRC32_LENGTH   = 32;
  localparam int LEN_LSB        = CRC32_LENGTH + WIDTH_PRIORITY;
  localparam int LEN_MSB        = LEN_LSB + WIDTH_LENGTH - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  typedef logic [WIDTH_SEL-1:0]    port_t;
  typedef logic [WIDTH_LENGTH-1:0] len_t;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } fifo_word_t;

  function automatic port_t hdrDest(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1 -: WIDTH_SEL];
  endfunction

  function automatic len_t hdrLen(input logic [DATA_WIDTH-1:0] w);
    return w[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/reg_fifo.sv
// Register-based FIFO with combinational head read and a registered full flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q;
  logic             doPush, doPop;

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && (!full_q || doPop);

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + CW'(1);
    end else if (!doPush && doPop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (doPush) wptr_q <= wptr_q + AW'(1);
      if (doPop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;

endmodule

// File: rtl/voq_seq_tagger.sv
// Ingress segmenter: buffers MAC words and tags each with dest port and a running sequence nub.
// Define SEQ_TAGGER_LEN_CHECK_EN to honour in_eop, pad short frames and count length errors.
module voq_seq_tagger
  import voq_seq_tagger_pkg::*;
#(
  parameter int IN_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  input  logic                            in_sop,
  input  logic                            in_eop,
  output logic                            in_ready,
  input  logic                            keep_in,
  output logic [WIDTH_SEL+DATA_WIDTH-1:0] data_out,
  output logic [WIDTH_SEL-1:0]            nub_out,
  output logic                            valid_out
`ifdef SEQ_TAGGER_LEN_CHECK_EN
  ,
  output logic [15:0]                     err_cnt
`endif
);

  fifo_word_t wrWord, headWord;
  logic       fifoEmpty, fifoFull, popEn;

  logic [1:0] state_q, state_d;
  port_t      dest_q, dest_d, seq_q, seq_d;
  len_t       len_q, len_d;

  logic                            emit;
  port_t                           emitDest, emitNub;
  logic [DATA_WIDTH-1:0]           emitWord;
  logic                            outValid_q;
  logic [WIDTH_SEL+DATA_WIDTH-1:0] outData_q;
  port_t                           outNub_q;

  assign wrWord = '{sop: in_sop, eop: in_eop, data: in_data};

  reg_fifo #(
    .WIDTH($bits(fifo_word_t)),
    .DEPTH(IN_DEPTH)
  ) u_in_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (in_valid && in_ready),
    .wdata_i(wrWord),
    .pop_i  (popEn),
    .rdata_o(headWord),
    .empty_o(fifoEmpty),
    .full_o (fifoFull)
  );

  assign in_ready = !fifoFull;

`ifdef SEQ_TAGGER_LEN_CHECK_EN
  logic        errInc;
  logic [15:0] errCnt_q;
`else
  logic unusedEop;
  assign unusedEop = headWord.eop;
`endif

  // Headers without eop count as late-eop errors only when the length check is built in.
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    seq_d    = seq_q;
    len_d    = len_q;
    popEn    = 1'b0;
    emit     = 1'b0;
    emitDest = dest_q;
    emitNub  = seq_q;
    emitWord = headWord.data;
`ifdef SEQ_TAGGER_LEN_CHECK_EN
    errInc   = 1'b0;
`endif
    if (!keep_in) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifoEmpty) begin
            popEn = 1'b1;
            if (headWord.sop) begin
              emit     = 1'b1;
              dest_d   = hdrDest(headWord.data);
              emitDest = dest_d;
              emitNub  = dest_d;
              seq_d    = dest_d + port_t'(1);
              len_d    = hdrLen(headWord.data);
              if (len_d == '0) begin
                state_d = ST_IDLE;
`ifdef SEQ_TAGGER_LEN_CHECK_EN
                errInc  = !headWord.eop;
`endif
              end else begin
                state_d = ST_BODY;
`ifdef SEQ_TAGGER_LEN_CHECK_EN
                if (headWord.eop) state_d = ST_PAD;
`endif
              end
            end
          end
        end
        ST_BODY: begin
          if (!fifoEmpty) begin
            popEn = 1'b1;
            emit  = 1'b1;
            seq_d = seq_q + port_t'(1);
            len_d = len_q - len_t'(1);
            if (len_q == len_t'(1)) begin
              state_d = ST_IDLE;
`ifdef SEQ_TAGGER_LEN_CHECK_EN
              errInc  = !headWord.eop;
`endif
            end
`ifdef SEQ_TAGGER_LEN_CHECK_EN
            else if (headWord.eop) begin
              state_d = ST_PAD;
            end
`endif
          end
        end
`ifdef SEQ_TAGGER_LEN_CHECK_EN
        ST_PAD: begin
          emit     = 1'b1;
          emitWord = '0;
          seq_d    = seq_q + port_t'(1);
          len_d    = len_q - len_t'(1);
          if (len_q == len_t'(1)) begin
            state_d = ST_IDLE;
            errInc  = 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output slice only moves while downstream is not stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dest_q     <= '0;
      seq_q      <= '0;
      len_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outNub_q   <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      seq_q   <= seq_d;
      len_q   <= len_d;
      if (!keep_in) begin
        outValid_q <= emit;
        if (emit) begin
          outData_q <= {emitDest, emitWord};
          outNub_q  <= emitNub;
        end
      end
    end
  end

`ifdef SEQ_TAGGER_LEN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt_q <= '0;
    end else if (errInc && (errCnt_q != 16'hFFFF)) begin
      errCnt_q <= errCnt_q + 16'd1;
    end
  end

  assign err_cnt = errCnt_q;
`endif

  assign valid_out = outValid_q;
  assign data_out  = outData_q;
  assign nub_out   = outNub_q;

endmodule

// File: tb/tb_voq_seq_tagger.sv
// Scoreboard bench for voq_seq_tagger; expectations are queued as words are driven.
// Header layout assumed here: dest in [63:61], length in [42:35].
module tb_voq_seq_tagger;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready, keep_in;
  logic [66:0] data_out;
  logic [2:0]  nub_out;
  logic        valid_out;
`ifdef SEQ_TAGGER_LEN_CHECK_EN
  logic [15:0] err_cnt;
`endif

  typedef struct {
    logic [2:0]  dest;
    logic [63:0] word;
    logic [2:0]  nub;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  voq_seq_tagger #(.IN_DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_ready (in_ready),
    .keep_in  (keep_in),
    .data_out (data_out),
    .nub_out  (nub_out),
    .valid_out(valid_out)
`ifdef SEQ_TAGGER_LEN_CHECK_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkHdr(input logic [2:0] dest, input logic [7:0] len,
                                        input logic [15:0] tag);
    logic [63:0] w;
    w = 64'h0;
    w[63:61] = dest;
    w[42:35] = len;
    w[15:0]  = tag;
    return w;
  endfunction

  function automatic logic [63:0] mkBody(input logic [15:0] tag);
    return {16'hB0D0, 32'h0, tag};
  endfunction

  task automatic checkOutput(input string tag, input logic [66:0] obs, input logic [66:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expPush(input logic [2:0] dest, input logic [63:0] word, input logic [2:0] nub);
    exp_t e;
    e.dest = dest;
    e.word = word;
    e.nub  = nub;
    expQ.push_back(e);
  endtask

  // Drives one word and returns 1 time unit after the edge that accepted it.
  task automatic applyStimulus(input logic [63:0] d, input logic sop, input logic eop);
    logic rdy;
    int   guard;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_valid = 1'b1;
    guard    = 0;
    rdy      = 1'b0;
    while (!rdy && guard < 100) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    if (!rdy) checkOutput("accept_timeout", 67'(rdy), 67'd1);
  endtask

  task automatic sendFrame(input logic [2:0] dest, input int len, input logic [15:0] tag);
    logic [63:0] w;
    w = mkHdr(dest, 8'(len), tag);
    expPush(dest, w, dest);
    applyStimulus(w, 1'b1, len == 0);
    for (int i = 1; i <= len; i++) begin
      w = mkBody(tag + 16'(i));
      expPush(dest, w, 3'(int'(dest) + i));
      applyStimulus(w, 1'b0, i == len);
    end
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain_left", 67'(expQ.size()), 67'd0);
  endtask

  // A slice is consumed on the edge where it is valid and not stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_out && !keep_in) begin
      nChecks++;
      assert (expQ.size() != 0) else begin
        nFails++;
        $error("[TB] FAIL unexpected_slice observed nub=%0d data=%h expected none", nub_out, data_out);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("slice_data", data_out, {e.dest, e.word});
        checkOutput("slice_nub", 67'(nub_out), 67'(e.nub));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] w, b2;
    clk = 1'b0; rst_n = 1'b0; in_data = '0; in_valid = 1'b0;
    in_sop = 1'b0; in_eop = 1'b0; keep_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 67'(valid_out), 67'd0);
    checkOutput("rst_data", data_out, 67'd0);
    checkOutput("rst_nub", 67'(nub_out), 67'd0);
    checkOutput("rst_ready", 67'(in_ready), 67'd1);
`ifdef SEQ_TAGGER_LEN_CHECK_EN
    checkOutput("rst_err", 67'(err_cnt), 67'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic frame dest=3 len=4 with latency");
    w = mkHdr(3'd3, 8'd4, 16'h0100);
    expPush(3'd3, w, 3'd3);
    applyStimulus(w, 1'b1, 1'b0);
    checkOutput("lat_n1_valid", 67'(valid_out), 67'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_n2_valid", 67'(valid_out), 67'd1);
    checkOutput("lat_n2_nub", 67'(nub_out), 67'd3);
    checkOutput("lat_n2_dest", 67'(data_out[66:64]), 67'd3);
    for (int i = 1; i <= 4; i++) begin
      w = mkBody(16'h0100 + 16'(i));
      expPush(3'd3, w, 3'(3 + i));
      applyStimulus(w, 1'b0, i == 4);
    end
    waitDrain();

    $display("[TB] nub wrap dest=6 len=3");
    sendFrame(3'd6, 3, 16'h0200);
    waitDrain();

    $display("[TB] mid-body stall and buffer fill");
    w = mkHdr(3'd1, 8'd11, 16'h0300);
    expPush(3'd1, w, 3'd1);
    applyStimulus(w, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      w = mkBody(16'h0300 + 16'(i));
      expPush(3'd1, w, 3'(1 + i));
      applyStimulus(w, 1'b0, 1'b0);
    end
    keep_in = 1'b1;
    b2 = mkBody(16'h0302);
    for (int c = 0; c < 4; c++) begin
      checkOutput("hold_valid", 67'(valid_out), 67'd1);
      checkOutput("hold_data", data_out, {3'd1, b2});
      checkOutput("hold_nub", 67'(nub_out), 67'd3);
      if (c < 3) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 4; i <= 10; i++) begin
      w = mkBody(16'h0300 + 16'(i));
      expPush(3'd1, w, 3'(1 + i));
      applyStimulus(w, 1'b0, 1'b0);
    end
    checkOutput("full_ready", 67'(in_ready), 67'd0);
    checkOutput("full_nub_held", 67'(nub_out), 67'd3);
    keep_in = 1'b0;
    w = mkBody(16'h030B);
    expPush(3'd1, w, 3'(1 + 11));
    applyStimulus(w, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] zero-length header then dest=2 len=1");
    sendFrame(3'd0, 0, 16'h0400);
    sendFrame(3'd2, 1, 16'h0410);
    waitDrain();

    $display("[TB] early eop on body word 2 of a len=5 frame");
    w = mkHdr(3'd5, 8'd5, 16'h0500);
    expPush(3'd5, w, 3'd5);
    applyStimulus(w, 1'b1, 1'b0);
    w = mkBody(16'h0501);
    expPush(3'd5, w, 3'd6);
    applyStimulus(w, 1'b0, 1'b0);
    w = mkBody(16'h0502);
    expPush(3'd5, w, 3'd7);
    applyStimulus(w, 1'b0, 1'b1);
`ifdef SEQ_TAGGER_LEN_CHECK_EN
    expPush(3'd5, 64'h0, 3'd0);
    expPush(3'd5, 64'h0, 3'd1);
    expPush(3'd5, 64'h0, 3'd2);
    sendFrame(3'd4, 1, 16'h0510);
    sendFrame(3'd7, 0, 16'h0520);
    waitDrain();
    checkOutput("early_eop_err", 67'(err_cnt), 67'd1);
`else
    w = mkHdr(3'd4, 8'd1, 16'h0510);
    expPush(3'd5, w, 3'd0);
    applyStimulus(w, 1'b1, 1'b0);
    w = mkBody(16'h0511);
    expPush(3'd5, w, 3'd1);
    applyStimulus(w, 1'b0, 1'b1);
    w = mkHdr(3'd7, 8'd0, 16'h0520);
    expPush(3'd5, w, 3'd2);
    applyStimulus(w, 1'b1, 1'b1);
    waitDrain();
`endif

    $display("[TB] reset in mid-frame then fresh frame");
    w = mkHdr(3'd6, 8'd6, 16'h0600);
    expPush(3'd6, w, 3'd6);
    applyStimulus(w, 1'b1, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      w = mkBody(16'h0600 + 16'(i));
      expPush(3'd6, w, 3'(6 + i));
      applyStimulus(w, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midrst_valid", 67'(valid_out), 67'd0);
    checkOutput("midrst_data", data_out, 67'd0);
    checkOutput("midrst_nub", 67'(nub_out), 67'd0);
    checkOutput("midrst_ready", 67'(in_ready), 67'd1);
    @(posedge clk);
    #1;
    checkOutput("midrst_valid_hold", 67'(valid_out), 67'd0);
`ifdef SEQ_TAGGER_LEN_CHECK_EN
    checkOutput("midrst_err", 67'(err_cnt), 67'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendFrame(3'd2, 2, 16'h0700);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/voq_seq_tagger.md
# voq_seq_tagger

Ingress-side frame segmenter that feeds the shared-memory switch fabric. Accepts whole frames word by word from the port MAC, tags every word with its destination port and a per-frame sequence number, and emits the tagged stream on the `{valid, nub, data}` slice bus. Downstream reorder logic relies on that tag to reassemble frames. Sequence numbers start at the destination port index and increment once per word.

## Interface
Parameters:
- `IN_DEPTH`, default 8: input buffer depth in words; power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  `DATA_WIDTH`  frame word. The header word carries the destination port in `[DATA_WIDTH-1 -: WIDTH_SEL]` and the body length in `[WIDTH_LENGTH+CRC32_LENGTH+WIDTH_PRIORITY-1 : CRC32_LENGTH+WIDTH_PRIORITY]`.
- `in_valid`  in  1  word valid.
- `in_sop`  in  1  marks the header word.
- `in_eop`  in  1  marks the last word. Used only with the macro below.
- `in_ready`  out  1  high while the buffer is not full.
- `keep_in`  in  1  downstream stall. Freezes the output register and the FSM.
- `data_out`  out  `WIDTH_SEL+DATA_WIDTH`  `{dest_port, word}`.
- `nub_out`  out  `WIDTH_SEL`  sequence tag.
- `valid_out`  out  1  slice valid.
- `err_cnt`  out  16  length-mismatch count. Present only with the macro.

## Operation
- A word is accepted when `in_valid & in_ready`. It is written into the buffer together with its sop and eop flags.
- FSM states: `IDLE`, `BODY`. The FSM advances only when `!keep_in`.
- In `IDLE`, when the buffer is non-empty:
  - If the head word has sop set: pop it, latch `dest`, load `len_reg` from the length field, emit it with `nub = dest`, and set `seq = dest+1`. If the length is 0, stay in `IDLE`; otherwise go to `BODY`.
  - A head word without sop is popped and discarded (resync).
- In `BODY`, when the buffer is non-empty: pop, emit with `nub = seq`, `seq++`, `len_reg--`. When `len_reg` reaches 1 before the decrement, return to `IDLE`.
- `seq` is `WIDTH_SEL` bits wide and wraps modulo 2^WIDTH_SEL. `len_reg` is `WIDTH_LENGTH` bits wide.
- Whenever no word is emitted in a cycle and `!keep_in`, `valid_out` is 0. `data_out` and `nub_out` then hold their last values.
- Any header with `len >= DATA_LENGTH_MAX` is truncated to the field width. No check is made.
- Simultaneous push and pop on a full buffer is allowed. `in_ready` reflects the registered full flag only, with no same-cycle bypass.
- Reset mid-frame clears the buffer and all counters. The FSM returns to `IDLE`, and words that were in flight are lost.

## Timing
- Reset values: `valid_out`=0, `data_out`=0, `nub_out`=0, `in_ready`=1, `err_cnt`=0.
- Latency: a word accepted in cycle N into an empty buffer appears on `valid_out` in cycle N+2, provided `keep_in` is low in N+1.
- Throughput: one word per cycle sustained.
- While `keep_in` is high, the outputs hold bit-exact, nothing is popped, and `in_ready` falls once the buffer fills.

## Configuration
Macro `SEQ_TAGGER_LEN_CHECK_EN`.
- **Defined:**
  - `in_eop` is honoured and the `err_cnt` port exists.
  - Early eop (eop popped while `len_reg` > 1): the FSM enters a third state `PAD`. It emits zero words with continuing `nub` until the length is satisfied, then increments `err_cnt`. While in `PAD` it does not pop.
  - Late eop (length satisfied without eop): the following non-sop words up to and including eop are discarded, and `err_cnt` increments once.
  - `err_cnt` saturates at 0xFFFF.
- **Undefined:** the length field alone delimits frames, `in_eop` is ignored, and there is no `PAD` state or `err_cnt` port.

## Structure
- `WIDTH_SEL`, `WIDTH_LENGTH`, `WIDTH_PRIORITY`, `CRC32_LENGTH`, the length-field offset, and the FSM state encodings belong in the shared package.
- The input buffer is the existing `reg_fifo` sub-module, instantiated with width `DATA_WIDTH+2` and depth `IN_DEPTH`. The FSM and output register are inline.

## Test plan
- Header with dest=3 and len=4, followed by 4 body words, with `keep_in`=0 → 5 slices with `nub` 3,4,5,6,7, `data_out[top]`=3, and the first `valid_out` two cycles after the header is accepted.
- With `PORT_NUB_TOTAL`=8 (`WIDTH_SEL`=3), dest=6 and len=3 → `nub` 6,7,0,1, showing the wrap.
- `keep_in` held high for 3 cycles in mid-body → outputs frozen for those 3 cycles, then the sequence resumes with no gap or duplicate. Feeding 12 words with `IN_DEPTH`=8 makes `in_ready` drop to 0.
- Header with len=0, then a second header with dest=2 and len=1 → slices with `nub` 0 (dest 0), then 2, 3, and the FSM passes through `IDLE` in between.
- With the macro defined: len=5 but eop on body word 2 → 2 real words and 3 zero-pad words are emitted, and `err_cnt`=1. Without the macro, the same stimulus consumes the next frame's header as body.
- Assert `rst_n` low in mid-frame, then send a fresh frame → outputs are zero during reset, and the new frame is tagged from its own dest.
